// File: rtl/fp_addsub_seq_if.sv
// Operand/result handshake bundle for fp_addsub_seq.
interface fp_addsub_seq_if #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned FRAC_W = 23
);
  localparam int unsigned W = 1 + EXP_W + FRAC_W;

  logic         in_valid;
  logic         in_ready;
  logic         op;
  logic [W-1:0] numA;
  logic [W-1:0] numB;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   out_flags;

  modport slave (
    input  in_valid, op, numA, numB, out_ready,
    output in_ready, out_valid, result, out_flags
  );

  modport master (
    output in_valid, op, numA, numB, out_ready,
    input  in_ready, out_valid, result, out_flags
  );
endinterface

// File: rtl/fp_addsub_seq.sv
// Multi-cycle FP add/sub: IDLE, ALIGN, ADD, NORM, ROUND, DONE; subnormals flushed to zero.
// FP_ADDSUB_RNE_EN selects round-to-nearest-even; otherwise the result is truncated.
module fp_addsub_seq #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned FRAC_W = 23
) (
  input  logic           clk,
  input  logic           rst,
  fp_addsub_seq_if.slave bus
);
  localparam int unsigned W   = 1 + EXP_W + FRAC_W;
  localparam int unsigned SW  = FRAC_W + 4;
  localparam int unsigned MW  = FRAC_W + 2;
  localparam int unsigned EW  = EXP_W + 2;
  localparam int unsigned LZW = $clog2(SW + 1);
  localparam logic [W-1:0]  QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
  localparam logic [EW-1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} state_t;

  state_t            r_state, w_next;
  logic [W-1:0]      r_a, r_b, r_result, r_spec_res;
  logic [3:0]        r_flags, r_spec_flags;
  logic              r_sign_l, r_sign_s, r_special, r_zero;
  logic [EXP_W-1:0]  r_exp;
  logic [SW-1:0]     r_sig_l, r_sig_s, r_nsig;
  logic [SW:0]       r_sum;
  logic [EW-1:0]     r_nexp;

  // Unpack, flush zero-exponent inputs, order by magnitude
  logic [EXP_W-1:0]  w_ea, w_eb, w_exp_l, w_exp_s, w_diff;
  logic [FRAC_W-1:0] w_fa, w_fb;
  logic              w_a_zero, w_b_zero, w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_swap, w_sticky;
  logic [W-2:0]      w_mag_a, w_mag_b;
  logic [SW-1:0]     w_sig_a, w_sig_b, w_sig_l, w_sig_s, w_shr;

  assign w_ea     = r_a[W-2:FRAC_W];
  assign w_eb     = r_b[W-2:FRAC_W];
  assign w_fa     = r_a[FRAC_W-1:0];
  assign w_fb     = r_b[FRAC_W-1:0];
  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_a_nan  = (&w_ea) && (|w_fa);
  assign w_b_nan  = (&w_eb) && (|w_fb);
  assign w_a_inf  = (&w_ea) && !(|w_fa);
  assign w_b_inf  = (&w_eb) && !(|w_fb);
  assign w_mag_a  = w_a_zero ? '0 : r_a[W-2:0];
  assign w_mag_b  = w_b_zero ? '0 : r_b[W-2:0];
  assign w_swap   = (w_mag_b > w_mag_a);
  assign w_sig_a  = w_a_zero ? '0 : {1'b1, w_fa, 3'b000};
  assign w_sig_b  = w_b_zero ? '0 : {1'b1, w_fb, 3'b000};
  assign w_sig_l  = w_swap ? w_sig_b : w_sig_a;
  assign w_sig_s  = w_swap ? w_sig_a : w_sig_b;
  assign w_exp_l  = w_swap ? w_eb : w_ea;
  assign w_exp_s  = w_swap ? w_ea : w_eb;
  assign w_diff   = w_exp_l - w_exp_s;
  assign w_shr    = w_sig_s >> w_diff;
  assign w_sticky = ((w_shr << w_diff) != w_sig_s);

  // Special-operand result bypasses the arithmetic path
  logic         w_special;
  logic [W-1:0] w_spec_res;
  logic [3:0]   w_spec_flags;
  always_comb begin
    w_special    = w_a_nan || w_b_nan || w_a_inf || w_b_inf;
    w_spec_res   = r_b;
    w_spec_flags = 4'b0000;
    if (w_a_nan || w_b_nan) begin
      w_spec_res = QNAN;
    end else if (w_a_inf && w_b_inf && (r_a[W-1] != r_b[W-1])) begin
      w_spec_res   = QNAN;
      w_spec_flags = 4'b1000;
    end else if (w_a_inf) begin
      w_spec_res = r_a;
    end
  end

  logic [SW:0] w_sum;
  assign w_sum = (r_sign_l == r_sign_s) ? ({1'b0, r_sig_l} + {1'b0, r_sig_s})
                                        : ({1'b0, r_sig_l} - {1'b0, r_sig_s});

  logic [LZW-1:0] w_lzc;
  always_comb begin
    w_lzc = '0;
    for (int i = 0; i < SW; i++) begin
      if (r_sum[i]) w_lzc = LZW'(SW - 1 - i);
    end
  end

  logic [SW-1:0] w_norm_sig;
  logic [EW-1:0] w_norm_exp;
  assign w_norm_sig = r_sum[SW] ? {r_sum[SW:2], |r_sum[1:0]} : (r_sum[SW-1:0] << w_lzc);
  assign w_norm_exp = r_sum[SW] ? ({2'b00, r_exp} + EW'(1)) : ({2'b00, r_exp} - EW'(w_lzc));

  // Rounding and range checks
  logic              w_inc, w_inexact, w_ovf, w_unf;
  logic [MW-1:0]     w_mant_r;
  logic [EW-1:0]     w_rexp;
  logic [FRAC_W-1:0] w_frac;
  logic [W-1:0]      w_res;
  logic [3:0]        w_flags;
`ifdef FP_ADDSUB_RNE_EN
  assign w_inc = r_nsig[2] & (r_nsig[1] | r_nsig[0] | r_nsig[3]);
`else
  assign w_inc = 1'b0;
`endif
  assign w_inexact = |r_nsig[2:0];
  assign w_mant_r  = {1'b0, r_nsig[SW-1:3]} + MW'(w_inc);
  assign w_rexp    = w_mant_r[MW-1] ? (r_nexp + EW'(1)) : r_nexp;
  assign w_frac    = w_mant_r[MW-1] ? w_mant_r[FRAC_W:1] : w_mant_r[FRAC_W-1:0];
  assign w_ovf     = !w_rexp[EW-1] && (w_rexp >= EXP_MAX);
  assign w_unf     = w_rexp[EW-1] || (w_rexp == '0);

  always_comb begin
    w_res   = {r_sign_l, w_rexp[EXP_W-1:0], w_frac};
    w_flags = {3'b000, w_inexact};
    if (r_special) begin
      w_res   = r_spec_res;
      w_flags = r_spec_flags;
    end else if (r_zero) begin
      w_res   = {r_sign_l & r_sign_s, {(W-1){1'b0}}};
      w_flags = 4'b0000;
    end else if (w_ovf) begin
      w_res   = {r_sign_l, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      w_flags = 4'b0101;
    end else if (w_unf) begin
      w_res   = {r_sign_l, {(W-1){1'b0}}};
      w_flags = 4'b0011;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid) w_next = S_ALIGN;
      S_ALIGN: w_next = S_ADD;
      S_ADD:   w_next = S_NORM;
      S_NORM:  w_next = S_ROUND;
      S_ROUND: w_next = S_DONE;
      S_DONE:  if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    case (r_state)
      S_IDLE: if (bus.in_valid) begin
        r_a <= bus.numA;
        r_b <= {bus.numB[W-1] ^ bus.op, bus.numB[W-2:0]};
      end
      S_ALIGN: begin
        r_sign_l     <= w_swap ? r_b[W-1] : r_a[W-1];
        r_sign_s     <= w_swap ? r_a[W-1] : r_b[W-1];
        r_exp        <= w_exp_l;
        r_sig_l      <= w_sig_l;
        r_sig_s      <= w_shr | SW'(w_sticky);
        r_special    <= w_special;
        r_spec_res   <= w_spec_res;
        r_spec_flags <= w_spec_flags;
      end
      S_ADD: r_sum <= w_sum;
      S_NORM: begin
        r_nsig <= w_norm_sig;
        r_nexp <= w_norm_exp;
        r_zero <= (r_sum == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_flags  <= '0;
    end else if (r_state == S_ROUND) begin
      r_result <= w_res;
      r_flags  <= w_flags;
    end
  end

  // in_ready is gated by rst so nothing is accepted while reset is asserted
  assign bus.in_ready  = (r_state == S_IDLE) && !rst;
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.result    = r_result;
  assign bus.out_flags = r_flags;
endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed scoreboard bench for fp_addsub_seq (single and double precision instances).
module tb_fp_addsub_seq;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [63:0] res;
    logic [3:0]  flags;
  } want_t;
  want_t sb_q[$];

`ifdef FP_ADDSUB_RNE_EN
  localparam logic [63:0] RND_RES = 64'h3F800001;
`else
  localparam logic [63:0] RND_RES = 64'h3F800000;
`endif

  fp_addsub_seq_if #(.EXP_W(8),  .FRAC_W(23)) s_if ();
  fp_addsub_seq_if #(.EXP_W(11), .FRAC_W(52)) d_if ();

  fp_addsub_seq #(.EXP_W(8),  .FRAC_W(23)) u_sp (.clk(clk), .rst(rst), .bus(s_if));
  fp_addsub_seq #(.EXP_W(11), .FRAC_W(52)) u_dp (.clk(clk), .rst(rst), .bus(d_if));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  function automatic logic [63:0] f_res(input bit dp);
    return dp ? d_if.result : {32'h0, s_if.result};
  endfunction
  function automatic logic [3:0] f_flags(input bit dp);
    return dp ? d_if.out_flags : s_if.out_flags;
  endfunction
  function automatic logic f_valid(input bit dp);
    return dp ? d_if.out_valid : s_if.out_valid;
  endfunction
  function automatic logic f_ready(input bit dp);
    return dp ? d_if.in_ready : s_if.in_ready;
  endfunction

  task automatic drive(input bit dp, input logic v, input logic o,
                       input logic [63:0] a, input logic [63:0] b);
    if (dp) begin
      d_if.in_valid = v; d_if.op = o; d_if.numA = a; d_if.numB = b;
    end else begin
      s_if.in_valid = v; s_if.op = o; s_if.numA = a[31:0]; s_if.numB = b[31:0];
    end
  endtask

  task automatic set_ready(input bit dp, input logic r);
    if (dp) d_if.out_ready = r;
    else    s_if.out_ready = r;
  endtask

  // One transaction: accept, latency, result/flags, optional hold in DONE, release
  task automatic run_op(input string tag, input bit dp, input logic [63:0] a, input logic [63:0] b,
                        input logic o, input logic [63:0] er, input logic [3:0] ef,
                        input int hold, input bit junk);
    want_t w;
    int    cnt;
    @(negedge clk);
    drive(dp, 1'b1, o, a, b);
    sb_q.push_back('{res: er, flags: ef});
    #1 check({tag, " in_ready_idle"}, 80'(f_ready(dp)), 80'(1));
    @(posedge clk);
    @(negedge clk);
    if (junk) drive(dp, 1'b1, ~o, b, a);
    else      drive(dp, 1'b0, 1'b0, '0, '0);
    cnt = 1;
    check({tag, " in_ready_busy"}, 80'(f_ready(dp)), 80'(0));
    while (f_valid(dp) !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, " latency"}, 80'(cnt), 80'(5));
    w = sb_q.pop_front();
    check({tag, " result"}, 80'(f_res(dp)), 80'(w.res));
    check({tag, " flags"}, 80'(f_flags(dp)), 80'(w.flags));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check({tag, " hold"}, 80'({f_valid(dp), f_ready(dp), f_flags(dp), f_res(dp)}),
            80'({1'b1, 1'b0, w.flags, w.res}));
    end
    set_ready(dp, 1'b1);
    drive(dp, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    set_ready(dp, 1'b0);
    check({tag, " release"}, 80'({f_valid(dp), f_ready(dp)}), 80'(2'b01));
  endtask

  initial begin
    logic saw;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    set_ready(1'b0, 1'b0);
    set_ready(1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("reset_sp", 80'({s_if.out_valid, s_if.in_ready, s_if.out_flags, s_if.result}), 80'(0));
    check("reset_dp", 80'({d_if.out_valid, d_if.in_ready, d_if.out_flags, d_if.result}), 80'(0));
    rst = 1'b0;
    #1 check("ready_after_reset", 80'(s_if.in_ready), 80'(1));

    run_op("one_plus_one",   1'b0, 64'h3F800000, 64'h3F800000, 1'b0, 64'h40000000, 4'b0000, 0, 1'b1);
    run_op("one_minus_one",  1'b0, 64'h3F800000, 64'h3F800000, 1'b1, 64'h00000000, 4'b0000, 0, 1'b0);
    run_op("negz_plus_negz", 1'b0, 64'h80000000, 64'h80000000, 1'b0, 64'h80000000, 4'b0000, 0, 1'b0);
    run_op("negz_plus_posz", 1'b0, 64'h80000000, 64'h00000000, 1'b0, 64'h00000000, 4'b0000, 0, 1'b0);
    run_op("inf_minus_inf",  1'b0, 64'h7F800000, 64'hFF800000, 1'b0, 64'h7FC00000, 4'b1000, 0, 1'b0);
    run_op("overflow",       1'b0, 64'h7F7FFFFF, 64'h7F7FFFFF, 1'b0, 64'h7F800000, 4'b0101, 0, 1'b0);
    run_op("round_grs",      1'b0, 64'h3F800000, 64'h33C00000, 1'b0, RND_RES,      4'b0001, 3, 1'b1);
    run_op("round_tie_even", 1'b0, 64'h3F800000, 64'h33800000, 1'b0, 64'h3F800000, 4'b0001, 0, 1'b0);
    run_op("three_minus_1",  1'b0, 64'h40400000, 64'h3F800000, 1'b1, 64'h40000000, 4'b0000, 0, 1'b0);
    run_op("one_minus_two",  1'b0, 64'h3F800000, 64'h40000000, 1'b1, 64'hBF800000, 4'b0000, 0, 1'b0);
    run_op("one_plus_1p5",   1'b0, 64'h3F800000, 64'h3FC00000, 1'b0, 64'h40200000, 4'b0000, 0, 1'b0);
    run_op("nan_operand",    1'b0, 64'h7F800001, 64'h3F800000, 1'b0, 64'h7FC00000, 4'b0000, 0, 1'b0);
    run_op("ninf_plus_fin",  1'b0, 64'hFF800000, 64'h3F800000, 1'b0, 64'hFF800000, 4'b0000, 0, 1'b0);
    run_op("fin_minus_inf",  1'b0, 64'h3F800000, 64'h7F800000, 1'b1, 64'hFF800000, 4'b0000, 0, 1'b0);
    run_op("subnorm_flush",  1'b0, 64'h00000001, 64'h3F800000, 1'b0, 64'h3F800000, 4'b0000, 0, 1'b0);
    run_op("underflow",      1'b0, 64'h00800000, 64'h00800001, 1'b1, 64'h80000000, 4'b0011, 0, 1'b0);
    run_op("dp_one_plus_2",  1'b1, 64'h3FF0000000000000, 64'h4000000000000000, 1'b0,
           64'h4008000000000000, 4'b0000, 0, 1'b0);
    run_op("dp_three_min_1", 1'b1, 64'h4008000000000000, 64'h3FF0000000000000, 1'b1,
           64'h4000000000000000, 4'b0000, 0, 1'b0);

    // Reset while the operation sits in NORM
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 64'h3F800000, 64'h3F800000);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 check("rst_norm_state", 80'({s_if.out_valid, s_if.in_ready}), 80'(2'b01));
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (s_if.out_valid === 1'b1) saw = 1'b1;
    end
    check("rst_norm_no_valid", 80'(saw), 80'(0));

    // Reset and in_valid together: nothing accepted
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 64'h3F800000, 64'h3F800000);
    #1 check("rst_in_valid_ready", 80'(s_if.in_ready), 80'(0));
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (s_if.out_valid === 1'b1) saw = 1'b1;
    end
    check("rst_in_valid_no_valid", 80'(saw), 80'(0));

    run_op("after_reset", 1'b0, 64'h3F800000, 64'h3F800000, 1'b0, 64'h40000000, 4'b0000, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
